imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Registered, flow-controlled successor to the combinational immediate decoder. Sits between fetch and execute.
- Per instruction it decodes and sign-extends the immediate to DATA_SIZE, classifies the immediate format and flags illegal opcodes.
- Computes the control-transfer target (branch/JAL: PC+imm; JALR: (rs1+imm)&~1).
- Valid/ready handshake with a 2-entry skid buffer, so it sustains one instruction per cycle with a registered o_ready.

Parameters:
- DATA_SIZE, 32, datapath/immediate width; legal values 32 or 64.
- INST_SIZE, 32, instruction width; fixed at 32.
- ADDR_SIZE, DATA_SIZE, PC/target width.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_flush  input  1  synchronous squash of all held entries.
- i_valid  input  1  upstream instruction valid.
- o_ready  output  1  stage can accept; registered.
- i_instr  input  INST_SIZE  instruction.
- i_pc  input  ADDR_SIZE  instruction PC.
- i_jalr_reg  input  DATA_SIZE  rs1 value for JALR.
- o_valid  output  1  output entry valid.
- i_ready  input  1  downstream accepts.
- o_immediate  output  DATA_SIZE  sign-extended immediate.
- o_imm_fmt  output  3  t_imm_fmt: NONE, I, S, B, U, J.
- o_target  output  ADDR_SIZE  transfer target; 0 for non-transfer opcodes.
- o_illegal  output  1  opcode unrecognised or instr[1:0]!=2'b11.

Behaviour:
- Reset (async, i_rst=1):
  - o_valid=0, o_ready=1, skid empty.
  - o_immediate, o_target, o_imm_fmt=NONE and o_illegal all 0.
- Accept: i_valid&&o_ready. Transfer out: o_valid&&i_ready.
- Latency: an instruction accepted in cycle N is presented with o_valid=1 in cycle N+1 when the output register is free or drains in cycle N.
- Output register loads when empty or transferring out. Source is the skid entry if full, otherwise the incoming accept.
- If the output register is held (o_valid && !i_ready) and an accept occurs, the decoded result goes to the skid entry.
- o_ready next = !(skid full next).
- Skid full with output held: o_ready=0. Upstream must hold i_valid/i_instr stable.
- Order is strictly preserved; no drops, no duplicates.
- Decode is combinational on input and registered with the entry. Immediate per opcode:
  - LOADS, ALC_I, JALR: instr[31:20] -> fmt I.
  - STORES: {instr[31:25], instr[11:7]} -> fmt S.
  - BRANCHES: {31, 7, 30:25, 11:8, 0} -> fmt B.
  - LUI, AUIPC: {instr[31:12], 12'h0} -> fmt U.
  - JAL: {31, 19:12, 20, 30:21, 0} -> fmt J.
- All immediates are sign-extended from instr[31] to DATA_SIZE, including U-type at 64-bit.
- ALC_R, FENCE, SYSTEM: imm 0, fmt NONE, legal.
- Any other opcode: imm 0, fmt NONE, o_illegal=1. Outputs are never X.
- Target arithmetic:
  - BRANCHES/JAL: i_pc + imm, modulo 2^ADDR_SIZE (wraps silently).
  - JALR: (i_jalr_reg + imm) & ~1, modulo 2^ADDR_SIZE.
- i_flush=1:
  - Next cycle o_valid=0, skid empty, o_ready=1.
  - An accept in the same cycle as the flush is discarded.
  - Flush has priority over accept and transfer.
- Simultaneous transfer-out and accept with skid empty: passthrough into the output register, throughput 1/cycle.
- Reset asserted mid-stream: all entries dropped immediately (async). First accept is possible on the first clock after deassertion.

Decomposition:
- Shared package additions:
  - t_imm_fmt enum (3 bits).
  - Opcode constants ALC_R, FENCE, SYSTEM added to t_opcode.
  - sign_extend function parametrised on DATA_SIZE.
  - Reuse existing t_opcode, DATA_SIZE and INST_SIZE.
- Sub-module imm_decode_core: pure combinational decode (imm, fmt, illegal, target).
- The handshake/skid logic stays in imm_decode_stage.

Test Plan:
- ADDI 0xFFF00093 -> o_immediate=0xFFFFFFFF, fmt I, o_illegal=0, o_valid one cycle after accept.
- BEQ 0xFE000EE3, i_pc=0x100 -> o_immediate=0xFFFFFFFC, fmt B, o_target=0x000000FC.
- JALR 0x004100E7, i_jalr_reg=0x1001 -> o_immediate=4, o_target=0x1004.
- DATA_SIZE=64: LUI 0x80000037 -> o_immediate=0xFFFFFFFF80000000. Opcode 0x00000000 -> o_illegal=1, imm 0, fmt NONE.
- Backpressure: 4 back-to-back valids, i_ready=0 for 3 cycles:
  - Two entries held, o_ready=0 from the third cycle.
  - Release -> all 4 emerge in order, no gap once streaming.
- Flush with both entries full plus a simultaneous accept -> next cycle o_valid=0, o_ready=1, flushed items never appear. i_rst pulse mid-stream -> o_valid drops same cycle.

Source files
------------

// File: rtl/imm_decode_stage_pkg.sv
// Shared opcode, immediate-format and sign-extension definitions for the
// decode stage and its combinational core.
package imm_decode_stage_pkg;

    localparam int unsigned DEFAULT_DATA_SIZE = 32;
    localparam int unsigned DEFAULT_INST_SIZE = 32;
    localparam int unsigned MAX_DATA_SIZE     = 64;

    typedef enum logic [6:0] {
        LOADS    = 7'b0000011,
        FENCE    = 7'b0001111,
        ALC_I    = 7'b0010011,
        AUIPC    = 7'b0010111,
        STORES   = 7'b0100011,
        ALC_R    = 7'b0110011,
        LUI      = 7'b0110111,
        BRANCHES = 7'b1100011,
        JALR     = 7'b1100111,
        JAL      = 7'b1101111,
        SYSTEM   = 7'b1110011
    } t_opcode;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } t_imm_fmt;

    // Widest legal extension; callers truncate to their DATA_SIZE.
    function automatic logic [MAX_DATA_SIZE-1:0] sign_extend(input logic [31:0] value);
        return {{(MAX_DATA_SIZE-32){value[31]}}, value};
    endfunction

endpackage

// File: rtl/imm_decode_stage_core.sv
// Pure combinational immediate decode: immediate, format, illegal flag and
// control-transfer target for one instruction.
module imm_decode_core
    import imm_decode_stage_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int unsigned INST_SIZE = DEFAULT_INST_SIZE,
    parameter int unsigned ADDR_SIZE = DATA_SIZE
) (
    input  logic [INST_SIZE-1:0] instr,
    input  logic [ADDR_SIZE-1:0] pc,
    input  logic [DATA_SIZE-1:0] jalr_reg,
    output logic [DATA_SIZE-1:0] immediate_c,
    output t_imm_fmt             imm_fmt_c,
    output logic [ADDR_SIZE-1:0] target_c,
    output logic                 illegal_c
);

    logic [31:0]          imm32;
    logic [ADDR_SIZE-1:0] imm_addr;

    // Every format is assembled as a 32-bit value already extended from instr[31].
    always_comb begin
        imm32     = 32'h0;
        imm_fmt_c = IMM_NONE;
        illegal_c = 1'b0;
        case (instr[6:0])
            LOADS, ALC_I, JALR: begin
                imm32     = {{20{instr[31]}}, instr[31:20]};
                imm_fmt_c = IMM_I;
            end
            STORES: begin
                imm32     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                imm_fmt_c = IMM_S;
            end
            BRANCHES: begin
                imm32     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                imm_fmt_c = IMM_B;
            end
            LUI, AUIPC: begin
                imm32     = {instr[31:12], 12'h000};
                imm_fmt_c = IMM_U;
            end
            JAL: begin
                imm32     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                imm_fmt_c = IMM_J;
            end
            ALC_R, FENCE, SYSTEM: begin
            end
            default: illegal_c = 1'b1;
        endcase
    end

    assign immediate_c = DATA_SIZE'(sign_extend(imm32));
    assign imm_addr    = ADDR_SIZE'(immediate_c);

    // Targets wrap modulo 2^ADDR_SIZE; JALR clears bit 0.
    always_comb begin
        target_c = '0;
        case (instr[6:0])
            BRANCHES, JAL: target_c = pc + imm_addr;
            JALR:          target_c = (ADDR_SIZE'(jalr_reg) + imm_addr) & ~ADDR_SIZE'(1);
            default:       target_c = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a valid/ready handshake and a
// two-entry (output + skid) buffer giving full throughput with registered ready.
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int unsigned INST_SIZE = DEFAULT_INST_SIZE,
    parameter int unsigned ADDR_SIZE = DATA_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [INST_SIZE-1:0] i_instr,
    input  logic [ADDR_SIZE-1:0] i_pc,
    input  logic [DATA_SIZE-1:0] i_jalr_reg,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_SIZE-1:0] o_immediate,
    output t_imm_fmt             o_imm_fmt,
    output logic [ADDR_SIZE-1:0] o_target,
    output logic                 o_illegal
);

    typedef struct packed {
        logic [DATA_SIZE-1:0] immediate;
        t_imm_fmt             imm_fmt;
        logic [ADDR_SIZE-1:0] target;
        logic                 illegal;
    } t_entry;

    t_entry dec;
    t_entry out_q, out_d, skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   ready_q, ready_d;
    logic   accept, transfer;

    imm_decode_core #(
        .DATA_SIZE(DATA_SIZE),
        .INST_SIZE(INST_SIZE),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_core (
        .instr      (i_instr),
        .pc         (i_pc),
        .jalr_reg   (i_jalr_reg),
        .immediate_c(dec.immediate),
        .imm_fmt_c  (dec.imm_fmt),
        .target_c   (dec.target),
        .illegal_c  (dec.illegal)
    );

    assign accept   = i_valid && ready_q;
    assign transfer = out_valid_q && i_ready;

    // Skid only fills while the output is held, so ready_q == !skid_valid_q
    // and no accept can arrive while the skid entry is occupied.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || transfer) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = dec;
                end
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign o_valid     = out_valid_q;
    assign o_ready     = ready_q;
    assign o_immediate = out_q.immediate;
    assign o_imm_fmt   = out_q.imm_fmt;
    assign o_target    = out_q.target;
    assign o_illegal   = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed cases plus randomized traffic against
// an in-order queue model of the stage and an arithmetic decode reference.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, valid, ready, valid64, ready64;
    logic [31:0] instr, pc, jr;
    logic [63:0] pc64, jr64;

    logic        o_ready, o_valid, o_ill;
    logic [31:0] o_imm, o_tgt;
    logic [2:0]  o_fmt;
    logic        o_ready64, o_valid64, o_ill64;
    logic [63:0] o_imm64, o_tgt64;
    logic [2:0]  o_fmt64;

    int checks   = 0;
    int failures = 0;
    bit last_acc = 1'b0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] tgt;
        logic        ill;
    } exp_t;
    exp_t q[$];

    imm_decode_stage #(.DATA_SIZE(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
        .i_instr(instr), .i_pc(pc), .i_jalr_reg(jr), .o_valid(o_valid), .i_ready(ready),
        .o_immediate(o_imm), .o_imm_fmt(o_fmt), .o_target(o_tgt), .o_illegal(o_ill)
    );

    imm_decode_stage #(.DATA_SIZE(64)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid64), .o_ready(o_ready64),
        .i_instr(instr), .i_pc(pc64), .i_jalr_reg(jr64), .o_valid(o_valid64), .i_ready(ready64),
        .o_immediate(o_imm64), .o_imm_fmt(o_fmt64), .o_target(o_tgt64), .o_illegal(o_ill64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode from the ISA field layout, computed as signed integers.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] pcv,
                                        input logic [63:0] jrv, input int w);
        exp_t        e;
        longint      v;
        logic [63:0] mask;
        mask  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        v     = 0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        e.tgt = 64'h0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: begin v = longint'($signed(ins[31:20])); e.fmt = 3'd1; end
            7'h23: begin v = longint'($signed({ins[31:25], ins[11:7]})); e.fmt = 3'd2; end
            7'h63: begin
                v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                e.fmt = 3'd3;
            end
            7'h37, 7'h17: begin v = longint'($signed({ins[31:12], 12'h000})); e.fmt = 3'd4; end
            7'h6F: begin
                v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                e.fmt = 3'd5;
            end
            7'h33, 7'h0F, 7'h73: v = 0;
            default: e.ill = 1'b1;
        endcase
        e.imm = 64'(v) & mask;
        if (ins[6:0] == 7'h63 || ins[6:0] == 7'h6F) e.tgt = (pcv + 64'(v)) & mask;
        else if (ins[6:0] == 7'h67) e.tgt = (jrv + 64'(v)) & mask & ~64'd1;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 12))
            0:  r[6:0] = 7'h03;
            1:  r[6:0] = 7'h13;
            2:  r[6:0] = 7'h67;
            3:  r[6:0] = 7'h23;
            4:  r[6:0] = 7'h63;
            5:  r[6:0] = 7'h37;
            6:  r[6:0] = 7'h17;
            7:  r[6:0] = 7'h6F;
            8:  r[6:0] = 7'h33;
            9:  r[6:0] = 7'h0F;
            10: r[6:0] = 7'h73;
            default: r = r;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] addi(input int k);
        return (32'(k) << 20) | 32'h0000_0013;
    endfunction

    // One clock of the 32-bit stage: update the model from pre-edge handshake, then check.
    task automatic tick();
        exp_t e;
        bit   acc, xf;
        acc = valid && o_ready;
        xf  = o_valid && ready;
        if (flush) begin
            q.delete();
        end else begin
            if (xf) begin
                chk("xfer_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("xfer_imm", 64'(o_imm), e.imm);
                    chk("xfer_fmt", 64'(o_fmt), 64'(e.fmt));
                    chk("xfer_tgt", 64'(o_tgt), e.tgt);
                    chk("xfer_ill", 64'(o_ill), 64'(e.ill));
                end
            end
            if (acc) q.push_back(ref_decode(instr, {32'h0, pc}, {32'h0, jr}, 32));
        end
        last_acc = acc && !flush;
        @(posedge clk);
        #1;
        chk("occ_valid", 64'(o_valid), 64'(q.size() != 0));
        chk("occ_ready", 64'(o_ready), 64'(q.size() < 2));
    endtask

    logic [31:0] bp [4];

    initial begin
        rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b1;
        valid64 = 1'b0; ready64 = 1'b1;
        instr = 32'h0; pc = 32'h0; jr = 32'h0; pc64 = 64'h0; jr64 = 64'h0;

        #1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_imm", 64'(o_imm), 64'd0);
        chk("rst_fmt", 64'(o_fmt), 64'd0);
        chk("rst_tgt", 64'(o_tgt), 64'd0);
        chk("rst_ill", 64'(o_ill), 64'd0);
        chk("rst_valid64", 64'(o_valid64), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ADDI x1, x0, -1
        valid = 1'b1; instr = 32'hFFF0_0093;
        tick();
        valid = 1'b0;
        chk("addi_valid", 64'(o_valid), 64'd1);
        chk("addi_imm", 64'(o_imm), 64'hFFFF_FFFF);
        chk("addi_fmt", 64'(o_fmt), 64'd1);
        chk("addi_ill", 64'(o_ill), 64'd0);

        // BEQ backwards by 4 from 0x100
        valid = 1'b1; instr = 32'hFE00_0EE3; pc = 32'h100;
        tick();
        valid = 1'b0;
        chk("beq_imm", 64'(o_imm), 64'hFFFF_FFFC);
        chk("beq_fmt", 64'(o_fmt), 64'd3);
        chk("beq_tgt", 64'(o_tgt), 64'h0000_00FC);

        // JALR with odd base clears bit 0
        valid = 1'b1; instr = 32'h0041_00E7; jr = 32'h1001;
        tick();
        valid = 1'b0;
        chk("jalr_imm", 64'(o_imm), 64'd4);
        chk("jalr_fmt", 64'(o_fmt), 64'd1);
        chk("jalr_tgt", 64'(o_tgt), 64'h1004);

        // 64-bit instance: U-type sign extension and an illegal opcode
        valid64 = 1'b1; instr = 32'h8000_0037;
        tick();
        chk("lui64_valid", 64'(o_valid64), 64'd1);
        chk("lui64_imm", o_imm64, 64'hFFFF_FFFF_8000_0000);
        chk("lui64_fmt", 64'(o_fmt64), 64'd4);
        chk("lui64_tgt", o_tgt64, 64'd0);
        instr = 32'h0000_0000;
        tick();
        valid64 = 1'b0;
        chk("ill64_flag", 64'(o_ill64), 64'd1);
        chk("ill64_imm", o_imm64, 64'd0);
        chk("ill64_fmt", 64'(o_fmt64), 64'd0);
        tick();

        // Backpressure: four back-to-back instructions, downstream stalled 3 cycles
        for (int i = 0; i < 4; i++) bp[i] = addi(i + 1);
        ready = 1'b0; valid = 1'b1; instr = bp[0];
        begin
            int idx;
            idx = 0;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (last_acc) begin
                    idx++;
                    if (idx < 4) instr = bp[idx]; else valid = 1'b0;
                end
                if (c >= 1) chk("bp_ready_low", 64'(o_ready), 64'd0);
            end
            chk("bp_head_imm", 64'(o_imm), 64'd1);
            ready = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                chk("bp_stream_valid", 64'(o_valid), 64'd1);
                chk("bp_stream_order", 64'(o_imm), 64'(k));
                tick();
                if (last_acc) begin
                    idx++;
                    if (idx < 4) instr = bp[idx]; else valid = 1'b0;
                end
            end
            valid = 1'b0;
        end

        // Flush with both entries full and a pending input
        ready = 1'b0; valid = 1'b1; instr = addi(5);
        tick();
        instr = addi(6);
        tick();
        chk("fl_full_ready", 64'(o_ready), 64'd0);
        instr = addi(7); flush = 1'b1;
        tick();
        flush = 1'b0; valid = 1'b0;
        chk("fl_valid", 64'(o_valid), 64'd0);
        chk("fl_ready", 64'(o_ready), 64'd1);
        ready = 1'b1;
        tick();
        tick();

        // Flush concurrent with a real accept discards it
        ready = 1'b0; valid = 1'b1; instr = addi(8);
        tick();
        instr = addi(9); flush = 1'b1;
        tick();
        flush = 1'b0; valid = 1'b0;
        tick();
        chk("fl_discard", 64'(o_valid), 64'd0);
        valid = 1'b1; instr = addi(10); ready = 1'b1;
        tick();
        valid = 1'b0;
        chk("fl_after_imm", 64'(o_imm), 64'd10);
        tick();

        // Asynchronous reset mid-stream
        ready = 1'b0; valid = 1'b1; instr = addi(11);
        tick();
        instr = addi(12);
        tick();
        valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_ready", 64'(o_ready), 64'd1);
        chk("arst_imm", 64'(o_imm), 64'd0);
        q.delete();
        last_acc = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        valid = 1'b1; instr = addi(13); ready = 1'b1;
        tick();
        valid = 1'b0;
        chk("post_rst_valid", 64'(o_valid), 64'd1);
        chk("post_rst_imm", 64'(o_imm), 64'd13);

        // Randomized traffic; an unaccepted instruction is held stable
        for (int c = 0; c < 3000; c++) begin
            if (!(valid && !last_acc)) begin
                valid = ($urandom_range(0, 3) != 0);
                instr = rand_instr();
                pc    = $urandom;
                jr    = $urandom;
            end
            ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 63) == 0);
            tick();
        end
        flush = 1'b0; valid = 1'b0; ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
